// File: rtl/snake_move_ctrl_pkg.sv
// Shared types and constants for the snake game-step engine.
package snake_move_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [1:0] TOP_DIR   = 2'd0;
  localparam logic [1:0] DOWN_DIR  = 2'd1;
  localparam logic [1:0] LEFT_DIR  = 2'd2;
  localparam logic [1:0] RIGHT_DIR = 2'd3;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

endpackage

// File: rtl/snake_move_ctrl_step_timer.sv
// Game-tick divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
module snake_move_ctrl_step_timer #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game-step engine: head advance with wrap, segment shift, growth,
// self-collision and a registered per-cell occupancy lookup for the renderer.
module snake_move_ctrl
  import snake_move_ctrl_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 2500000
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [1:0]               iDirection,
  input  logic                     iStart,
  input  logic                     iGrow,
  input  logic [X_W-1:0]           iQueryX,
  input  logic [Y_W-1:0]           iQueryY,
  output logic                     oCellHit,
  output logic                     oCellHead,
  output logic [X_W-1:0]           oHeadX,
  output logic [Y_W-1:0]           oHeadY,
  output logic [$clog2(MAX_LEN):0] oLength,
  output logic                     oStep,
  output logic                     oGameOver
);

  localparam int L_W = $clog2(MAX_LEN) + 1;
  localparam logic [X_W-1:0] X_MAX  = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_INIT = X_W'(GRID_W / 2);
  localparam logic [L_W-1:0] L_INIT = L_W'(INIT_LEN);
  localparam logic [L_W-1:0] L_MAX  = L_W'(MAX_LEN);

  state_t state, state_nxt;

  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic [L_W-1:0] len;
  logic [L_W-1:0] chk_len;
  logic           grow_flag;
  logic           grow_eff;
  logic           running;
  logic           restart;
  logic           tick;
  logic           collide;
  logic           move;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [MAX_LEN-1:0] body_eq;
  logic [MAX_LEN-1:0] query_eq;

  assign running  = (state == S_RUN);
  assign restart  = !running && iStart;
  assign grow_eff = grow_flag || iGrow;

  snake_move_ctrl_step_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_step_timer (
    .clk  (iClk),
    .rst_n(iRst_n),
    .en   (running),
    .clr  (restart),
    .tick (tick)
  );

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (iDirection)
      TOP_DIR:   ny = (seg_y[0] == '0)    ? Y_MAX : seg_y[0] - 1'b1;
      DOWN_DIR:  ny = (seg_y[0] == Y_MAX) ? '0    : seg_y[0] + 1'b1;
      LEFT_DIR:  nx = (seg_x[0] == '0)    ? X_MAX : seg_x[0] - 1'b1;
      RIGHT_DIR: nx = (seg_x[0] == X_MAX) ? '0    : seg_x[0] + 1'b1;
      default:   nx = seg_x[0];
    endcase
  end

  // The tail cell is vacated by the move unless a grow keeps it in place.
  assign chk_len = grow_eff ? len : len - 1'b1;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    localparam logic [L_W-1:0] IDX = L_W'(i);
    assign body_eq[i]  = (seg_x[i] == nx) && (seg_y[i] == ny) && (IDX < chk_len);
    assign query_eq[i] = (seg_x[i] == iQueryX) && (seg_y[i] == iQueryY) && (IDX < len);
  end

  assign collide = tick && (|body_eq);
  assign move    = tick && !collide;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_RUN;
      S_RUN:   if (collide) state_nxt = S_OVER;
      S_OVER:  if (iStart) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_INIT;
        seg_y[i] <= Y_W'(GRID_H / 2 + i);
      end
    end else if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_INIT;
        seg_y[i] <= Y_W'(GRID_H / 2 + i);
      end
    end else if (move) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0] <= nx;
      seg_y[0] <= ny;
    end
  end

  // Growth is sticky until the next move; requests outside RUN are dropped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      len       <= L_INIT;
      grow_flag <= 1'b0;
    end else if (restart) begin
      len       <= L_INIT;
      grow_flag <= 1'b0;
    end else if (running) begin
      if (move) begin
        grow_flag <= 1'b0;
        if (grow_eff && (len != L_MAX)) len <= len + 1'b1;
      end else begin
        grow_flag <= grow_eff;
      end
    end else begin
      grow_flag <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oStep     <= 1'b0;
      oCellHit  <= 1'b0;
      oCellHead <= 1'b0;
    end else begin
      oStep     <= move;
      oCellHit  <= |query_eq;
      oCellHead <= query_eq[0];
    end
  end

  assign oHeadX    = seg_x[0];
  assign oHeadY    = seg_y[0];
  assign oLength   = len;
  assign oGameOver = (state == S_OVER);

endmodule
